pipe_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline registers (PC, IF_ID, ID_EX, EX_MEM).

---
 rtl/pipe_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and the
// mult/div freeze, plus a free-running count of stalled cycles.
module pipe_hazard_ctrl #(
  parameter  int MD_LATENCY = 4,
  localparam int CNT_W      = $clog2(MD_LATENCY + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        md_start,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               load_use;
  logic               freeze;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  // The final BUSY cycle (cnt==1) releases the pipeline so the result can advance.
  assign freeze = ((state == IDLE) && md_start) ||
                  ((state == BUSY) && (cnt > CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (md_start) begin
          state_nx = BUSY;
          cnt_nx   = CNT_W'(MD_LATENCY - 1);
        end
      end
      BUSY: begin
        // md_start stays high for the same instruction; it is not a new request here.
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (rst) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
    end else begin
      md_busy = (state == BUSY);
      md_done = (state == BUSY) && (cnt == CNT_W'(1));
      if (freeze) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        // Branch operands are stale behind the load, so the branch waits a cycle.
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// checked on two instances (MD_LATENCY 4 and 2) against a residence-position model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, md_start;

  logic [7:0]  out4, out2;
  logic [31:0] stall4, stall2;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: cycle number of the mult/div's residence in EX (0 = none).
  int pos4 = 0, pos2 = 0;
  logic [31:0] exp_stall4 = 0, exp_stall2 = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .md_start(md_start),
    .pc_en(out4[7]), .if_id_en(out4[6]), .if_id_flush(out4[5]),
    .id_ex_en(out4[4]), .id_ex_flush(out4[3]), .ex_mem_flush(out4[2]),
    .md_busy(out4[1]), .md_done(out4[0]), .stall_cycles(stall4)
  );

  pipe_hazard_ctrl #(.MD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .md_start(md_start),
    .pc_en(out2[7]), .if_id_en(out2[6]), .if_id_flush(out2[5]),
    .id_ex_en(out2[4]), .id_ex_flush(out2[3]), .ex_mem_flush(out2[2]),
    .md_busy(out2[1]), .md_done(out2[0]), .stall_cycles(stall2)
  );

  // Expected {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_flush,md_busy,md_done}
  function automatic logic [7:0] model(input logic r, input int cur, input int lat);
    logic pc, ifid, iffl, idex, idfl, exfl, lu, frz;
    if (r) return 8'h00;
    lu  = ex_mem_read && (ex_rt != 0) &&
          ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    frz = (cur >= 1) && (cur < lat);
    {pc, ifid, iffl, idex, idfl, exfl} = 6'b110100;
    if (frz) begin
      pc = 0; ifid = 0; idex = 0; exfl = 1;
    end else if (lu) begin
      pc = 0; ifid = 0; idfl = 1;
    end else if (branch_taken) begin
      iffl = 1;
    end
    return {pc, ifid, iffl, idex, idfl, exfl, (cur >= 2), (cur == lat)};
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: inputs already driven after negedge; check outputs, clock, check counters.
  task automatic step(input string tag);
    int c4, c2;
    logic [7:0] e4, e2;
    c4 = (pos4 > 0) ? pos4 : (md_start ? 1 : 0);
    c2 = (pos2 > 0) ? pos2 : (md_start ? 1 : 0);
    #1;
    e4 = model(rst, c4, 4);
    e2 = model(rst, c2, 2);
    chk8({tag, "_l4"}, out4, e4);
    chk8({tag, "_l2"}, out2, e2);
    if (rst) begin
      exp_stall4 = 0; exp_stall2 = 0;
    end else begin
      if (!e4[7]) exp_stall4++;
      if (!e2[7]) exp_stall2++;
    end
    pos4 = (rst || c4 == 0 || c4 == 4) ? 0 : c4 + 1;
    pos2 = (rst || c2 == 0 || c2 == 2) ? 0 : c2 + 1;
    @(posedge clk);
    #1;
    chk32({tag, "_stall_l4"}, stall4, exp_stall4);
    chk32({tag, "_stall_l2"}, stall2, exp_stall2);
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    branch_taken = 0; md_start = 0;
  endtask

  initial begin
    quiet();
    rst = 1;
    @(negedge clk);
    step("reset");
    step("reset2");
    quiet();
    step("idle");

    // Load-use on rs, then clear: exactly one bubble
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
    step("lu_rs");
    quiet();
    step("lu_after");
    ex_mem_read = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1;
    step("lu_rt");

    // r0 exemption and unused-operand match
    quiet(); ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1;
    step("r0_exempt");
    quiet(); ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 0;
    step("rs_unused");

    // Branch alone, then branch masked by load-use
    quiet(); branch_taken = 1;
    step("branch");
    ex_mem_read = 1; ex_rt = 3; id_rs = 3; id_uses_rs = 1;
    step("branch_lu");

    // Mult/div with load-use and branch in the start cycle, held for its residence
    md_start = 1;
    step("md_c1");
    quiet(); md_start = 1;
    step("md_c2");
    step("md_c3");
    step("md_c4");
    quiet();
    step("md_after");

    // Reset while busy (L=4 counter at 2), then idle
    md_start = 1;
    step("mdr_c1");
    step("mdr_c2");
    rst = 1;
    step("mdr_rst");
    quiet();
    step("mdr_idle");
    step("mdr_idle2");

    // Random traffic over a small register set so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rt        = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      if (pos4 > 0 || pos2 > 0) md_start = 1'($urandom_range(0, 3) != 0);
      else                      md_start = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
